// File: rtl/mp_cache_tag_ram.sv
// Set-associative cache tag RAM: per-set tags and valid bits, one-cycle registered lookup
// with lowest-way hit select, and a sequential flush that invalidates one set per cycle.
//   state | meaning
//   IDLE  | requests accepted; a flush pulse starts invalidation at set 0
//   FLUSH | busy; valid bits of set[cnt] cleared each cycle, requests ignored
module mp_cache_tag_ram #(
  parameter int TAG_WIDTH = 23,
  parameter int SET_WIDTH = 5,
  parameter int WAYS      = 4
) (
  input  logic                          clk0,
  input  logic                          rst0_n,
  input  logic                          csb0,
  input  logic                          web0,
  input  logic [SET_WIDTH-1:0]          addr0,
  input  logic [$clog2(WAYS)-1:0]       way0,
  input  logic [TAG_WIDTH-1:0]          din0,
  input  logic [TAG_WIDTH-1:0]          cmp_tag0,
  input  logic                          flush,
  output logic                          busy,
  output logic [WAYS*TAG_WIDTH-1:0]     dout0,
  output logic [WAYS-1:0]               valid0,
  output logic                          hit0,
  output logic [$clog2(WAYS)-1:0]       hit_way0
);

  localparam int WAY_WIDTH = $clog2(WAYS);
  localparam int DEPTH     = 2 ** SET_WIDTH;
  localparam logic [SET_WIDTH-1:0] LAST_SET = SET_WIDTH'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [SET_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   accept;
  logic                   clr_set;

  logic [SET_WIDTH-1:0]   addr_reg;
  logic [TAG_WIDTH-1:0]   cmp_reg;

  logic [TAG_WIDTH-1:0]   tag_mem   [DEPTH][WAYS];
  logic [WAYS-1:0]        valid_mem [DEPTH];

  logic [WAYS-1:0]        cur_valid;
  logic [WAYS-1:0]        match;

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A flush pulse in IDLE wins over a coincident request, which is dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    clr_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else if (!csb0) begin
          accept = 1'b1;
        end
      end
      FLUSH: begin
        clr_set = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_SET) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q == FLUSH);

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      addr_reg <= '0;
      cmp_reg  <= '0;
    end else if (accept) begin
      addr_reg <= addr0;
      cmp_reg  <= cmp_tag0;
    end
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      for (int s = 0; s < DEPTH; s++) begin
        valid_mem[s] <= '0;
      end
    end else if (clr_set) begin
      valid_mem[cnt_q] <= '0;
    end else if (accept && !web0) begin
      valid_mem[addr0][way0] <= 1'b1;
    end
  end

  // Tag contents survive reset and flush; only the valid bits gate their use.
  always_ff @(posedge clk0) begin
    if (accept && !web0) begin
      tag_mem[addr0][way0] <= din0;
    end
  end

  assign cur_valid = valid_mem[addr_reg];
  assign valid0    = cur_valid;

  always_comb begin
    dout0 = '0;
    match = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (cur_valid[i]) begin
        dout0[i*TAG_WIDTH +: TAG_WIDTH] = tag_mem[addr_reg][i];
        match[i] = (tag_mem[addr_reg][i] == cmp_reg) && !busy;
      end
    end
  end

  always_comb begin
    hit0     = |match;
    hit_way0 = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit_way0 = WAY_WIDTH'(i);
      end
    end
  end

endmodule

// File: tb/tb_mp_cache_tag_ram.sv
// Bench for mp_cache_tag_ram: a reference tag/valid model feeds a scoreboard queue that a
// monitor drains one cycle after each accepted request; flush and reset scenarios check inline.
module tb_mp_cache_tag_ram;

  localparam int TW = 23;
  localparam int SW = 5;
  localparam int NW = 4;
  localparam int NS = 32;

  logic              clk0 = 1'b0;
  logic              rst0_n;
  logic              csb0;
  logic              web0;
  logic [SW-1:0]     addr0;
  logic [1:0]        way0;
  logic [TW-1:0]     din0;
  logic [TW-1:0]     cmp_tag0;
  logic              flush;
  logic              busy;
  logic [NW*TW-1:0]  dout0;
  logic [NW-1:0]     valid0;
  logic              hit0;
  logic [1:0]        hit_way0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NW-1:0]    valid;
    logic             hit;
    logic [1:0]       hw;
    logic [NW*TW-1:0] dout;
  } exp_t;

  exp_t          sb_q[$];
  exp_t          sb_e;
  logic [TW-1:0] m_tag   [NS][NW];
  logic [NW-1:0] m_valid [NS];

  mp_cache_tag_ram #(.TAG_WIDTH(TW), .SET_WIDTH(SW), .WAYS(NW)) dut (
    .clk0(clk0), .rst0_n(rst0_n), .csb0(csb0), .web0(web0), .addr0(addr0),
    .way0(way0), .din0(din0), .cmp_tag0(cmp_tag0), .flush(flush), .busy(busy),
    .dout0(dout0), .valid0(valid0), .hit0(hit0), .hit_way0(hit_way0)
  );

  always #5 clk0 = ~clk0;

  function automatic exp_t model_out(input int s, input logic [TW-1:0] cmp);
    exp_t e;
    e.valid = m_valid[s];
    e.hit   = 1'b0;
    e.hw    = 2'd0;
    e.dout  = '0;
    for (int i = 0; i < NW; i++) begin
      if (m_valid[s][i]) begin
        e.dout[i*TW +: TW] = m_tag[s][i];
        if (!e.hit && m_tag[s][i] == cmp) begin
          e.hit = 1'b1;
          e.hw  = 2'(i);
        end
      end
    end
    return e;
  endfunction

  // Scoreboard monitor: outputs settle just after the edge that accepted the request.
  always @(posedge clk0) begin
    #1;
    if (sb_q.size() > 0) begin
      sb_e = sb_q.pop_front();
      checks++;
      if (valid0 !== sb_e.valid || hit0 !== sb_e.hit || hit_way0 !== sb_e.hw || dout0 !== sb_e.dout) begin
        errors++;
        $display("FAIL sb_lookup set=%0d: got valid=%b hit=%b way=%0d dout=%h, want valid=%b hit=%b way=%0d dout=%h",
                 dut.addr_reg, valid0, hit0, hit_way0, dout0, sb_e.valid, sb_e.hit, sb_e.hw, sb_e.dout);
      end
    end
  end

  task automatic idle_inputs();
    csb0 = 1'b1; web0 = 1'b1; flush = 1'b0;
    addr0 = '0; way0 = '0; din0 = '0; cmp_tag0 = '0;
  endtask

  // Called at a falling edge; one accepted request, returns at the next falling edge.
  task automatic req(input logic we_b, input int s, input int w, input logic [TW-1:0] d,
                     input logic [TW-1:0] cmp);
    csb0 = 1'b0; web0 = we_b; flush = 1'b0;
    addr0 = SW'(s); way0 = 2'(w); din0 = d; cmp_tag0 = cmp;
    if (!we_b) begin
      m_tag[s][w]   = d;
      m_valid[s][w] = 1'b1;
    end
    sb_q.push_back(model_out(s, cmp));
    @(posedge clk0);
    @(negedge clk0);
    csb0 = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst0_n = 1'b0;
    for (int s = 0; s < NS; s++) m_valid[s] = '0;
    #2;
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (hit0 !== 1'b0)   begin errors++; $display("FAIL reset_hit: got %b want 0", hit0); end
    checks++; if (hit_way0 !== 2'd0) begin errors++; $display("FAIL reset_hit_way: got %0d want 0", hit_way0); end
    checks++; if (valid0 !== 4'b0) begin errors++; $display("FAIL reset_valid: got %b want 0000", valid0); end
    checks++; if (dout0 !== '0)    begin errors++; $display("FAIL reset_dout: got %h want 0", dout0); end
    repeat (3) @(negedge clk0);
    rst0_n = 1'b1;
  endtask

  task automatic test_basic_hit();
    req(1'b0, 3, 2, 23'h12345, 23'h0);
    req(1'b1, 3, 0, 23'h0, 23'h12345);
    checks++; if (hit0 !== 1'b1) begin errors++; $display("FAIL basic_hit: got %b want 1", hit0); end
    checks++; if (hit_way0 !== 2'd2) begin errors++; $display("FAIL basic_hit_way: got %0d want 2", hit_way0); end
    checks++; if (valid0 !== 4'b0100) begin errors++; $display("FAIL basic_valid: got %b want 0100", valid0); end
  endtask

  task automatic test_multi_way();
    req(1'b0, 7, 1, 23'h5A5A5, 23'h0);
    req(1'b0, 7, 3, 23'h5A5A5, 23'h0);
    req(1'b1, 7, 0, 23'h0, 23'h5A5A5);
    checks++; if (hit0 !== 1'b1 || hit_way0 !== 2'd1)
      begin errors++; $display("FAIL multi_lowest_way: got hit=%b way=%0d want hit=1 way=1", hit0, hit_way0); end
    req(1'b1, 7, 0, 23'h0, 23'h0);
    checks++; if (hit0 !== 1'b0 || hit_way0 !== 2'd0)
      begin errors++; $display("FAIL multi_miss: got hit=%b way=%0d want hit=0 way=0", hit0, hit_way0); end
  endtask

  task automatic test_read_after_write();
    req(1'b0, 5, 0, 23'h7ABCD, 23'h0);
    req(1'b1, 5, 0, 23'h0, 23'h7ABCD);
    checks++; if (dout0[TW-1:0] !== 23'h7ABCD || valid0[0] !== 1'b1)
      begin errors++; $display("FAIL raw_way0: got tag=%h v=%b want tag=7abcd v=1", dout0[TW-1:0], valid0[0]); end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++) begin
      req(1'($urandom_range(0, 1)), $urandom_range(8, 15), $urandom_range(0, 3),
          TW'($urandom_range(0, 3)), TW'($urandom_range(0, 3)));
    end
  endtask

  // From a falling edge, pulse flush and count busy cycles while driving ignored writes.
  task automatic run_flush(input bit second_pulse, input int abort_at, output int cycles);
    flush = 1'b1; csb0 = 1'b1;
    @(posedge clk0);
    @(negedge clk0);
    flush = 1'b0;
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      if (abort_at != 0 && cycles == abort_at) return;
      checks++; if (hit0 !== 1'b0) begin errors++; $display("FAIL flush_hit_low: got %b want 0 at cycle %0d", hit0, cycles); end
      csb0 = 1'b0; web0 = 1'b0; addr0 = SW'(cycles); way0 = 2'(cycles);
      din0 = TW'(32'h6000 + cycles); cmp_tag0 = din0;
      flush = second_pulse && (cycles == 5);
      @(posedge clk0);
      @(negedge clk0);
    end
    idle_inputs();
    for (int s = 0; s < NS; s++) m_valid[s] = '0;
  endtask

  task automatic test_flush_full();
    int cyc;
    for (int s = 0; s < NS; s++) req(1'b0, s, s % NW, TW'(32'h100 + s), 23'h0);
    run_flush(1'b0, 0, cyc);
    checks++; if (cyc !== 32) begin errors++; $display("FAIL flush_busy_len: got %0d want 32", cyc); end
    for (int s = 0; s < NS; s++) begin
      req(1'b1, s, 0, 23'h0, TW'(32'h100 + s));
      checks++; if (hit0 !== 1'b0 || valid0 !== 4'b0)
        begin errors++; $display("FAIL flush_after set=%0d: got hit=%b valid=%b want 0 0000", s, hit0, valid0); end
    end
  endtask

  task automatic test_flush_drop();
    int cyc;
    req(1'b1, 9, 0, 23'h0, 23'h3C3C3);
    flush = 1'b1; csb0 = 1'b0; web0 = 1'b0; addr0 = 5'd9; way0 = 2'd1;
    din0 = 23'h3C3C3; cmp_tag0 = 23'h3C3C3;
    @(posedge clk0);
    @(negedge clk0);
    idle_inputs();
    checks++; if (busy !== 1'b1 || valid0 !== 4'b0)
      begin errors++; $display("FAIL drop_write: got busy=%b valid=%b want 1 0000", busy, valid0); end
    cyc = 1;
    while (busy === 1'b1 && cyc < 100) begin
      flush = (cyc == 5);
      @(posedge clk0);
      @(negedge clk0);
      flush = 1'b0;
      if (busy === 1'b1) cyc++;
    end
    checks++; if (cyc !== 32) begin errors++; $display("FAIL flush_no_extend: got %0d want 32", cyc); end
    for (int s = 0; s < NS; s++) m_valid[s] = '0;
    req(1'b1, 9, 0, 23'h0, 23'h3C3C3);
  endtask

  task automatic test_reset_mid_flush();
    int cyc;
    for (int s = 0; s < 4; s++) req(1'b0, s, 3 - s, TW'(32'h2200 + s), 23'h0);
    req(1'b1, 2, 0, 23'h0, 23'h2202);
    run_flush(1'b0, 10, cyc);
    checks++; if (cyc !== 10) begin errors++; $display("FAIL rst_flush_reach: got %0d want 10", cyc); end
    rst0_n = 1'b0;
    idle_inputs();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_abort_busy: got %b want 0", busy); end
    checks++; if (valid0 !== 4'b0 || hit0 !== 1'b0)
      begin errors++; $display("FAIL rst_abort_out: got valid=%b hit=%b want 0000 0", valid0, hit0); end
    for (int s = 0; s < NS; s++) m_valid[s] = '0;
    @(negedge clk0);
    @(negedge clk0);
    rst0_n = 1'b1;
    for (int s = 0; s < 4; s++) req(1'b1, s, 0, 23'h0, TW'(32'h2200 + s));
    req(1'b0, 2, 1, 23'h44444, 23'h0);
    req(1'b1, 2, 0, 23'h0, 23'h44444);
    checks++; if (hit0 !== 1'b1 || hit_way0 !== 2'd1 || valid0 !== 4'b0010)
      begin errors++; $display("FAIL rst_new_write: got hit=%b way=%0d valid=%b want 1 1 0010", hit0, hit_way0, valid0); end
  endtask

  initial begin
    test_reset();
    @(negedge clk0);
    test_basic_hit();
    test_multi_way();
    test_read_after_write();
    test_back_to_back();
    test_flush_full();
    test_flush_drop();
    test_reset_mid_flush();
    repeat (2) @(negedge clk0);
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d pending want 0", sb_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
